volume_ramp: RTL

- Generates the 6-bit volume level index that drives the gain-lookup stage, and presents it zero-extended to 32 bits on the level input of volumeControl.
- Accepts a target level from the HPS register path and from debounced up/down/mute pushbuttons.
- Slews the applied level by one step per RAMP_SAMPLES audio samples, so gain changes happen only between samples and zipper noise is avoided.
- Mute ramps down to level 0, then outputs index 63, which selects gain 0.

---
 rtl/volume_ramp.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/volume_ramp.sv
// Volume level slew controller: debounced buttons and HPS writes set a target level,
// and the applied level steps toward it once every RAMP_SAMPLES audio frames, with a mute ramp.
module volume_ramp #(
  parameter int unsigned MAX_LEVEL       = 40,
  parameter int unsigned UNITY_LEVEL     = 20,
  parameter int unsigned MUTE_CODE       = 63,
  parameter int unsigned RAMP_SAMPLES    = 48,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        sample_ready,
  input  logic [31:0] hps_target,
  input  logic        hps_target_valid,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_mute,
  output logic [31:0] vol_level_out,
  output logic        at_target,
  output logic        muted
);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_MUTING = 2'd1;
  localparam logic [1:0] ST_MUTED  = 2'd2;

  localparam int unsigned CW  = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [CW-1:0]  CNT_LAST = CW'(RAMP_SAMPLES - 1);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]     MAXL     = 6'(MAX_LEVEL);
  localparam logic [5:0]     UNITY    = 6'(UNITY_LEVEL);
  localparam logic [5:0]     MUTEC    = 6'(MUTE_CODE);

  // Button order in all vectors: [0]=up, [1]=down, [2]=mute.
  logic [2:0]     w_raw;
  logic [2:0]     r_sync1;
  logic [2:0]     r_sync2;
  logic [2:0]     r_db;
  logic [2:0]     r_db_d;
  logic [DBW-1:0] r_dbcnt [3];
  logic [2:0]     w_press;

  logic [5:0]     r_tgt;
  logic [5:0]     r_cur;
  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [5:0]     r_vol;
  logic           r_at;
  logic           r_muted;

  logic [5:0]     w_tgt_nxt;
  logic [5:0]     w_cur_nxt;
  logic [1:0]     w_state_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [5:0]     w_eff;
  logic           w_hold;
  logic           w_step;
  logic           w_up;
  logic           w_down;
  logic           w_mute;

  assign w_raw = {btn_mute, btn_down, btn_up};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        r_dbcnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      // The debounced value flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_dbcnt[i] == DB_LAST) begin
            r_db[i]    <= r_sync2[i];
            r_dbcnt[i] <= '0;
          end else begin
            r_dbcnt[i] <= r_dbcnt[i] + 1'b1;
          end
        end else begin
          r_dbcnt[i] <= '0;
        end
      end
    end
  end

  assign w_press = r_db & ~r_db_d;
  assign w_up    = w_press[0];
  assign w_down  = w_press[1];
  assign w_mute  = w_press[2];

  always_comb begin
    w_tgt_nxt = r_tgt;
    if (hps_target_valid) begin
      w_tgt_nxt = (hps_target > MAX_LEVEL) ? MAXL : hps_target[5:0];
    end else if (w_up && !w_down) begin
      if (r_tgt < MAXL) w_tgt_nxt = r_tgt + 6'd1;
    end else if (w_down && !w_up) begin
      if (r_tgt != '0) w_tgt_nxt = r_tgt - 6'd1;
    end
  end

  always_comb begin
    w_eff     = (r_state == ST_NORMAL) ? r_tgt : '0;
    // MUTING keeps counting at level 0 so it can reach its MUTED step boundary.
    w_hold    = (r_state != ST_MUTING) && (r_cur == w_eff);
    w_step    = sample_ready && !w_hold && (r_cnt == CNT_LAST);
    w_cnt_nxt = r_cnt;
    if (w_hold) begin
      w_cnt_nxt = '0;
    end else if (sample_ready) begin
      w_cnt_nxt = w_step ? '0 : r_cnt + 1'b1;
    end
    w_cur_nxt = r_cur;
    if (w_step) begin
      if (r_cur < w_eff) begin
        w_cur_nxt = r_cur + 6'd1;
      end else if (r_cur > w_eff) begin
        w_cur_nxt = r_cur - 6'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: if (w_mute) w_state_nxt = ST_MUTING;
      ST_MUTING: begin
        if (w_mute) begin
          w_state_nxt = ST_NORMAL;
        end else if (w_step && (w_cur_nxt == '0)) begin
          w_state_nxt = ST_MUTED;
        end
      end
      ST_MUTED:  if (w_mute) w_state_nxt = ST_NORMAL;
      default:   w_state_nxt = ST_NORMAL;
    endcase
  end

  // Outputs are registered from next-state values so they move with the state they describe.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_tgt   <= UNITY;
      r_cur   <= UNITY;
      r_state <= ST_NORMAL;
      r_cnt   <= '0;
      r_vol   <= UNITY;
      r_at    <= 1'b1;
      r_muted <= 1'b0;
    end else begin
      r_tgt   <= w_tgt_nxt;
      r_cur   <= w_cur_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_vol   <= (w_state_nxt == ST_MUTED) ? MUTEC : w_cur_nxt;
      r_at    <= ((w_state_nxt == ST_NORMAL) && (w_cur_nxt == w_tgt_nxt)) ||
                 (w_state_nxt == ST_MUTED);
      r_muted <= (w_state_nxt == ST_MUTED);
    end
  end

  assign vol_level_out = {26'b0, r_vol};
  assign at_target     = r_at;
  assign muted         = r_muted;

endmodule
